// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// Hits are combinational; a miss runs a single-word fill through FILL before hitting.
module icache #(
  parameter int NFRAMES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IW = $clog2(NFRAMES);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE, FILL} state_t;

  state_t               state, next_state;
  logic [NFRAMES-1:0]   valid;
  logic [TW-1:0]        tag_mem  [NFRAMES];
  logic [31:0]          data_mem [NFRAMES];

  logic [IW-1:0] index;
  logic [TW-1:0] tag;
  logic          hit;
  logic          fill_done;
  logic          unused_offset;

  assign index         = imemaddr[IW+1:2];
  assign tag           = imemaddr[31:IW+2];
  assign unused_offset = ^imemaddr[1:0];

  assign hit       = imemREN && valid[index] && (tag_mem[index] == tag) && (state == IDLE);
  assign fill_done = (state == FILL) && !iwait;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      valid <= '0;
    end else begin
      state <= next_state;
      if (fill_done) valid[index] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset so they can map onto plain RAM;
  // the valid bits alone make their power-up contents harmless.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_mem[index]  <= tag;
      data_mem[index] <= iload;
    end
  end

  // NOTE: every output is defaulted first so no path through the case
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    unique case (state)
      IDLE: begin
        ihit     = hit;
        // Unwritten frames read as zero so imemload is clean out of reset.
        imemload = valid[index] ? data_mem[index] : '0;
        if (imemREN && !hit) next_state = FILL;
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = {imemaddr[31:2], 2'b00};
        if (!iwait) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: table-driven fetch vectors with a data
// scoreboard, plus hand-written reset-mid-fill and request-drop sequences.
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  icache #(.NFRAMES(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int          nwait;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Backing memory contents, owned by the bench.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0) return 32'h2001_0005;
    return (w * 32'd2654435761) ^ 32'h0F0F_1234;
  endfunction

  // One fetch: hold the request until ihit, stretching the fill by nwait
  // busy cycles; checks data, latency and number of fill-request cycles.
  task automatic fetch(input logic [31:0] addr, input int nwait, input int exp_lat);
    int   c;
    int   iren_n;
    bit   got;
    exp_t e;
    sb_q.push_back('{addr: addr, data: mem_word(addr)});
    c = 0; iren_n = 0; got = 1'b0;
    while (!got && c < 40) begin
      @(negedge CLK);
      imemREN  = 1'b1;
      imemaddr = addr;
      iwait    = (c <= nwait);
      iload    = mem_word(addr);
      #1;
      if (iREN) begin
        iren_n++;
        check("fill_iaddr", iaddr, {addr[31:2], 2'b00});
        check("fill_no_ihit", {31'b0, ihit}, 32'd0);
      end
      if (ihit) begin
        got = 1'b1;
        e = sb_q.pop_front();
        check("fetch_data", imemload, e.data);
      end else begin
        c++;
      end
    end
    if (!got) begin
      check("fetch_timeout", {31'b0, got}, 32'd1);
      void'(sb_q.pop_front());
    end
    check("fetch_latency", c, exp_lat);
    check("fill_cycles", iren_n, (exp_lat == 0) ? 0 : exp_lat - 1);
  endtask

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    iwait    = 1'b1;
    iload    = '0;

    // Cold miss, warm pass, second (hit) pass, conflict, unaligned, wrap.
    vecs.push_back('{addr: 32'h0, nwait: 2, lat: 4});
    for (int i = 1; i < 16; i++) vecs.push_back('{addr: 32'(i * 4), nwait: 0, lat: 2});
    for (int i = 0; i < 16; i++) vecs.push_back('{addr: 32'(i * 4), nwait: 0, lat: 0});
    vecs.push_back('{addr: 32'h44, nwait: 1, lat: 3});
    vecs.push_back('{addr: 32'h04, nwait: 0, lat: 2});
    vecs.push_back('{addr: 32'h44, nwait: 0, lat: 2});
    vecs.push_back('{addr: 32'h04, nwait: 0, lat: 2});
    vecs.push_back('{addr: 32'h04, nwait: 0, lat: 0});
    vecs.push_back('{addr: 32'h08, nwait: 0, lat: 0});
    vecs.push_back('{addr: 32'h0B, nwait: 0, lat: 0});
    vecs.push_back('{addr: 32'h3C, nwait: 0, lat: 0});
    vecs.push_back('{addr: 32'h40, nwait: 0, lat: 2});
    vecs.push_back('{addr: 32'h00, nwait: 0, lat: 2});
    vecs.push_back('{addr: 32'h00, nwait: 0, lat: 0});

    // Reset state, before any clock edge.
    #2;
    check("rst_ihit", {31'b0, ihit}, 32'd0);
    check("rst_iREN", {31'b0, iREN}, 32'd0);
    check("rst_iaddr", iaddr, 32'd0);
    check("rst_imemload", imemload, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    foreach (vecs[i]) fetch(vecs[i].addr, vecs[i].nwait, vecs[i].lat);

    // No request: outputs quiet except imemload.
    @(negedge CLK);
    imemREN = 1'b0; imemaddr = 32'h8; #1;
    check("idle_ihit", {31'b0, ihit}, 32'd0);
    check("idle_iREN", {31'b0, iREN}, 32'd0);
    check("idle_iaddr", iaddr, 32'd0);
    check("idle_imemload", imemload, mem_word(32'h8));

    // Reset asserted mid-fill drops iREN without a clock edge.
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1; #1;
    check("rmf_miss", {31'b0, ihit}, 32'd0);
    @(negedge CLK);
    #1;
    check("rmf_fill_iREN", {31'b0, iREN}, 32'd1);
    #1 nRST = 1'b0;
    #1;
    check("rmf_async_iREN", {31'b0, iREN}, 32'd0);
    check("rmf_async_iaddr", iaddr, 32'd0);
    @(negedge CLK);
    imemREN = 1'b0; nRST = 1'b1;
    fetch(32'h100, 0, 2);
    fetch(32'h000, 0, 2);

    // imemREN drops during FILL; the fill still completes.
    @(negedge CLK);
    imemREN = 1'b1; imemaddr = 32'h200; iwait = 1'b1; iload = mem_word(32'h200); #1;
    check("drop_miss", {31'b0, ihit}, 32'd0);
    @(negedge CLK);
    imemREN = 1'b0; iwait = 1'b1; #1;
    check("drop_fill_iREN", {31'b0, iREN}, 32'd1);
    check("drop_fill_imemload", imemload, 32'd0);
    @(negedge CLK);
    iwait = 1'b0; #1;
    check("drop_last_iREN", {31'b0, iREN}, 32'd1);
    @(negedge CLK);
    iwait = 1'b1; #1;
    check("drop_after_iREN", {31'b0, iREN}, 32'd0);
    check("drop_after_ihit", {31'b0, ihit}, 32'd0);
    fetch(32'h200, 0, 0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
